// File: rtl/rld_pkg.sv
// Shared definitions for the run-length detector.
//   state_e  : run tracker state (no run / run of 0s / run of 1s)
//   sat_inc  : increment that sticks at a caller-supplied ceiling
package rld_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ZRUN = 2'b01,
        ORUN = 2'b10
    } state_e;

    // Operates on 32-bit values so one function serves every counter width;
    // callers cast in and out of their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, posedge
//   rst_i : synchronous active-high reset, highest priority
//   inc_i : count up by one (sticks at 2^WIDTH-1)
//   clr_i : force to zero, wins over inc_i
//   cnt_o : registered count
module sat_counter
    import rld_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << WIDTH) - 64'd1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = WIDTH'(sat_inc(32'(cnt_q), CNT_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/run_length_detector.sv
// Mealy run detector for a serial bit stream.
// Tracks the current run of identical bits and flags when its length reaches
// a programmable threshold, either on every bit of the run (CONT=1) or once
// per run (CONT=0). Counts match cycles in a saturating hit counter.
//   clk        : clock, posedge
//   RESET      : synchronous active-high reset
//   in_valid   : `in` carries a stream bit this cycle (0 = bubble)
//   in         : serial data bit
//   zero_len   : 0-run threshold, 0 disables zero matching
//   one_len    : 1-run threshold, 0 disables one matching
//   hit_clr    : clear hit_cnt
//   match_zero : combinational 0-run match for the current bit
//   match_one  : combinational 1-run match for the current bit
//   run_len    : registered, saturating length of the current run
//   hit_cnt    : registered, saturating count of match cycles
module run_length_detector
    import rld_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int HIT_W = 8,
    parameter int CONT  = 1
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             in_valid,
    input  logic             in,
    input  logic [CNT_W-1:0] zero_len,
    input  logic [CNT_W-1:0] one_len,
    input  logic             hit_clr,
    output logic             match_zero,
    output logic             match_one,
    output logic [CNT_W-1:0] run_len,
    output logic [HIT_W-1:0] hit_cnt
);

    localparam logic [31:0] RUN_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic        CONT_EN = (CONT != 0);

    state_e           state_q;
    logic [CNT_W-1:0] run_len_q;
    logic             fired_q;

    logic             same_run;
    logic             state_ok;
    logic [CNT_W-1:0] run_len_d;
    logic             fired_eff;
    logic             fired_d;
    logic             hit_inc;

    always_comb begin
        same_run = 1'b0;
        state_ok = 1'b1;
        case (state_q)
            IDLE:    same_run = 1'b0;
            ZRUN:    same_run = ~in;
            ORUN:    same_run = in;
            default: state_ok = 1'b0;
        endcase

        run_len_d = same_run ? CNT_W'(sat_inc(32'(run_len_q), RUN_MAX)) : CNT_W'(1);

        // A new run forgets that the previous run already fired.
        fired_eff = fired_q & same_run;

        match_zero = in_valid & state_ok & ~in & (zero_len != '0) &
                     (run_len_d >= zero_len) & (CONT_EN | ~fired_eff);
        match_one  = in_valid & state_ok &  in & (one_len != '0) &
                     (run_len_d >= one_len) & (CONT_EN | ~fired_eff);

        fired_d = ~CONT_EN & (fired_eff | match_zero | match_one);
        hit_inc = match_zero | match_one;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q   <= IDLE;
            run_len_q <= '0;
            fired_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ZRUN, ORUN: begin
                    // Bubbles leave the run untouched.
                    if (in_valid) begin
                        state_q   <= in ? ORUN : ZRUN;
                        run_len_q <= run_len_d;
                        fired_q   <= fired_d;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    run_len_q <= '0;
                    fired_q   <= 1'b0;
                end
            endcase
        end
    end

    assign run_len = run_len_q;

    sat_counter #(
        .WIDTH(HIT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .rst_i (RESET),
        .inc_i (hit_inc),
        .clr_i (hit_clr),
        .cnt_o (hit_cnt)
    );

endmodule

// File: tb/tb_run_length_detector.sv
module tb_run_length_detector;

    logic       clk;
    logic       rst;
    logic       vld;
    logic       b;
    logic [3:0] zl;
    logic [3:0] ol;
    logic       clr;

    // C: continuous, 8-bit hits.  P: pulse mode.  H: continuous, 2-bit hits.
    logic       mz_c, mo_c, mz_p, mo_p, mz_h, mo_h;
    logic [3:0] rl_c, rl_p, rl_h;
    logic [7:0] hit_c, hit_p;
    logic [1:0] hit_h;

    int checks = 0;
    int errors = 0;

    run_length_detector #(.CNT_W(4), .HIT_W(8), .CONT(1)) u_c (
        .clk(clk), .RESET(rst), .in_valid(vld), .in(b), .zero_len(zl), .one_len(ol),
        .hit_clr(clr), .match_zero(mz_c), .match_one(mo_c), .run_len(rl_c), .hit_cnt(hit_c));

    run_length_detector #(.CNT_W(4), .HIT_W(8), .CONT(0)) u_p (
        .clk(clk), .RESET(rst), .in_valid(vld), .in(b), .zero_len(zl), .one_len(ol),
        .hit_clr(clr), .match_zero(mz_p), .match_one(mo_p), .run_len(rl_p), .hit_cnt(hit_p));

    run_length_detector #(.CNT_W(4), .HIT_W(2), .CONT(1)) u_h (
        .clk(clk), .RESET(rst), .in_valid(vld), .in(b), .zero_len(zl), .one_len(ol),
        .hit_clr(clr), .match_zero(mz_h), .match_one(mo_h), .run_len(rl_h), .hit_cnt(hit_h));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, vld, b, clr;
        logic [3:0] zl, ol;
        logic       mz, mo;
        logic [3:0] rl;
        logic [7:0] hit;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic r, input logic v, input logic bb, input logic [3:0] z,
                                input logic [3:0] o, input logic c, input logic emz,
                                input logic emo, input logic [3:0] erl, input logic [7:0] eh);
        vec_t t;
        t.rst = r; t.vld = v; t.b = bb; t.zl = z; t.ol = o; t.clr = c;
        t.mz = emz; t.mo = emo; t.rl = erl; t.hit = eh;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual %0d required %0d", nm, idx, act, exp);
        end
    endtask

    // Drive a cycle's inputs and let combinational outputs settle.
    task automatic drive(input logic r, input logic v, input logic bb, input logic [3:0] z,
                         input logic [3:0] o, input logic c);
        rst = r; vld = v; b = bb; zl = z; ol = o; clr = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;

        // rst vld b  zl  ol  clr  mz mo rl hit
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 2, 0, 0, 0, 0, 1, 0);
        vecs[4]  = mk(0, 1, 0, 2, 0, 0, 1, 0, 2, 1);
        vecs[5]  = mk(0, 1, 0, 2, 0, 0, 1, 0, 3, 2);
        vecs[6]  = mk(0, 1, 0, 2, 0, 0, 1, 0, 4, 3);
        vecs[7]  = mk(0, 1, 1, 2, 0, 0, 0, 0, 1, 3);
        vecs[8]  = mk(0, 1, 0, 0, 3, 0, 0, 0, 1, 3);
        vecs[9]  = mk(0, 1, 1, 0, 3, 0, 0, 0, 1, 3);
        vecs[10] = mk(0, 1, 1, 0, 3, 0, 0, 0, 2, 3);
        vecs[11] = mk(0, 0, 1, 0, 3, 0, 0, 0, 2, 3);
        vecs[12] = mk(0, 0, 0, 0, 3, 0, 0, 0, 2, 3);
        vecs[13] = mk(0, 0, 1, 0, 3, 0, 0, 0, 2, 3);
        vecs[14] = mk(0, 1, 1, 0, 3, 0, 0, 1, 3, 4);
        vecs[15] = mk(0, 1, 0, 0, 15, 0, 0, 0, 1, 4);

        // Reset, continuous 0-run, 1-run across bubbles (instance C).
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].b, vecs[i].zl, vecs[i].ol, vecs[i].clr);
            chk("tbl_mz", i, 32'(mz_c), 32'(vecs[i].mz));
            chk("tbl_mo", i, 32'(mo_c), 32'(vecs[i].mo));
            tick();
            chk("tbl_rl", i, 32'(rl_c), 32'(vecs[i].rl));
            chk("tbl_hit", i, 32'(hit_c), 32'(vecs[i].hit));
        end

        // Twenty 1s against one_len=15: run_len saturates, matches persist.
        for (int i = 1; i <= 20; i++) begin
            drive(0, 1, 1, 0, 15, 0);
            chk("sat_mo", i, 32'(mo_c), (i >= 15) ? 32'd1 : 32'd0);
            tick();
            chk("sat_rl", i, 32'(rl_c), (i >= 15) ? 32'd15 : 32'(i));
            chk("sat_hit", i, 32'(hit_c), (i >= 15) ? 32'(4 + i - 14) : 32'd4);
        end

        // Reset mid-run, then pulse mode on instance P.
        drive(1, 1, 1, 0, 4, 0);
        tick();
        chk("rst_rl_p", 0, 32'(rl_p), 32'd0);
        chk("rst_hit_p", 0, 32'(hit_p), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 1, 0, 4, 0);
            chk("pulse_mo", i, 32'(mo_p), (i == 4) ? 32'd1 : 32'd0);
            tick();
            chk("pulse_rl", i, 32'(rl_p), 32'(i));
        end
        drive(0, 1, 0, 0, 4, 0);
        chk("pulse_mo_brk", 0, 32'(mo_p), 32'd0);
        tick();
        chk("pulse_rl_brk", 0, 32'(rl_p), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, 1, 0, 4, 0);
            chk("pulse2_mo", i, 32'(mo_p), (i == 4) ? 32'd1 : 32'd0);
            tick();
        end
        chk("pulse_hit", 0, 32'(hit_p), 32'd2);
        // Lowering the threshold below the current length fires exactly once.
        drive(0, 1, 0, 0, 4, 0);
        tick();
        drive(0, 1, 1, 0, 4, 0);
        tick();
        drive(0, 1, 1, 0, 4, 0);
        chk("lower_mo", 2, 32'(mo_p), 32'd0);
        tick();
        drive(0, 1, 1, 0, 2, 0);
        chk("lower_mo", 3, 32'(mo_p), 32'd1);
        tick();
        drive(0, 1, 1, 0, 2, 0);
        chk("lower_mo", 4, 32'(mo_p), 32'd0);
        tick();
        chk("lower_hit", 0, 32'(hit_p), 32'd3);

        // Hit counter saturation and clear priority on instance H.
        drive(1, 0, 0, 1, 0, 0);
        tick();
        chk("h_rst_hit", 0, 32'(hit_h), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            drive(0, 1, 0, 1, 0, 0);
            chk("h_mz", i, 32'(mz_h), 32'd1);
            tick();
            cnt = (i > 3) ? 3 : i;
            chk("h_hit", i, 32'(hit_h), 32'(cnt));
        end
        drive(0, 1, 0, 1, 0, 1);
        chk("h_clr_mz", 0, 32'(mz_h), 32'd1);
        tick();
        chk("h_clr_hit", 0, 32'(hit_h), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            chk("h_dis_mz", i, 32'(mz_h), 32'd0);
            chk("h_dis_mo", i, 32'(mo_h), 32'd0);
            tick();
            chk("h_dis_hit", i, 32'(hit_h), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
